// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit layout, widths, controller states and
// output-port codes used by the input controller and its route decoder.
package noc_pkg;

   localparam int COORD_W     = 2;
   localparam int FLIT_W      = 8;
   localparam int X_DES_LSB   = 0;
   localparam int Y_DES_LSB   = 2;
   localparam int PAYLOAD_LSB = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

   // Codes 6 and 7 are reserved and never produced.
   typedef enum logic [2:0] {
      PORT_NONE  = 3'd0,
      PORT_LOCAL = 3'd1,
      PORT_EAST  = 3'd2,
      PORT_WEST  = 3'd3,
      PORT_NORTH = 3'd4,
      PORT_SOUTH = 3'd5
   } port_t;

endpackage

// File: rtl/input_controller_if.sv
// FIFO-side and crossbar-side signals of one router input port; the
// controller takes the master view, the FIFO/switch environment the slave view.
interface input_controller_if;
   import noc_pkg::*;

   logic [COORD_W-1:0] X_cur;
   logic [COORD_W-1:0] Y_cur;
   logic [FLIT_W-1:0]  Data_in;
   logic               empty;
   logic               read;
   logic [FLIT_W-1:0]  Data_out;
   logic [2:0]         register;

   modport master (
      input  X_cur, Y_cur, Data_in, empty,
      output read, Data_out, register
   );

   modport slave (
      output X_cur, Y_cur, Data_in, empty,
      input  read, Data_out, register
   );

endinterface

// File: rtl/xy_route.sv
// XY dimension-order route decoder: X is resolved first, then Y, with plain
// unsigned compares (mesh edges, no wrap-around).
module xy_route
   import noc_pkg::*;
(
   input  logic [COORD_W-1:0] x_des_i,
   input  logic [COORD_W-1:0] y_des_i,
   input  logic [COORD_W-1:0] x_cur_i,
   input  logic [COORD_W-1:0] y_cur_i,
   output port_t              port_o
);

   always_comb begin
      port_o = PORT_LOCAL;
      if (x_des_i > x_cur_i) begin
         port_o = PORT_EAST;
      end else if (x_des_i < x_cur_i) begin
         port_o = PORT_WEST;
      end else if (y_des_i > y_cur_i) begin
         port_o = PORT_NORTH;
      end else if (y_des_i < y_cur_i) begin
         port_o = PORT_SOUTH;
      end
   end

endmodule

// File: rtl/input_controller.sv
// Router input-port controller: pops one flit per READ/LOAD/SEND pass, routes it
// XY-wise and presents flit plus port code to the switch stage for one cycle.
module input_controller
   import noc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input_controller_if.master  bus
);

   state_t             state_q, state_d;
   logic               read_q, read_d;
   port_t              port_q, port_d;
   logic [FLIT_W-1:0]  data_q, data_d;
   port_t              route_port;

   xy_route u_xy_route (
      .x_des_i (bus.Data_in[X_DES_LSB +: COORD_W]),
      .y_des_i (bus.Data_in[Y_DES_LSB +: COORD_W]),
      .x_cur_i (bus.X_cur),
      .y_cur_i (bus.Y_cur),
      .port_o  (route_port)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         read_q  <= 1'b0;
         port_q  <= PORT_NONE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         read_q  <= read_d;
         port_q  <= port_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      port_d  = PORT_NONE;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (!bus.empty) begin
               state_d = READ;
            end
         end
         // Pop is committed once in READ, so empty is not consulted here.
         READ: begin
            state_d = LOAD;
         end
         LOAD: begin
            state_d = SEND;
            data_d  = bus.Data_in;
            port_d  = route_port;
         end
         SEND: begin
            state_d = bus.empty ? IDLE : READ;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Pop strobe is registered alongside the state so it is high exactly in READ.
      read_d = (state_d == READ);
   end

   assign bus.read     = read_q;
   assign bus.Data_out = data_q;
   assign bus.register = port_q;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller: table-driven routing vectors,
// hand-written multi-cycle sequences and a randomized run against a timing model.
module tb_input_controller;
   import noc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   input_controller_if bus ();

   input_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] xc;
      logic [1:0] yc;
      logic [7:0] flit;
      int         exp_port;
   } vec_t;

   vec_t vecs [10];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Transaction-level model: a pop decided at edge p shows read after p,
   // flit/port after p+2, and the next decision can happen at edge p+3.
   int edge_n    = 0;
   int pop_edge  = -100;
   int free_edge = 0;
   int exp_read  = 0;
   int exp_reg   = 0;
   int exp_data  = 0;

   logic [7:0] fifo_q [$];
   bit         fifo_mode = 1'b0;

   function automatic int ref_route(input int xc, input int yc, input int xd, input int yd);
      if (xd > xc) return 2;
      if (xd < xc) return 3;
      if (yd > yc) return 4;
      if (yd < yc) return 5;
      return 1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pop_edge  = -100;
      free_edge = 0;
      exp_read  = 0;
      exp_reg   = 0;
      exp_data  = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".read"},     int'(bus.read),     exp_read);
      check({tag, ".register"}, int'(bus.register), exp_reg);
      check({tag, ".Data_out"}, int'(bus.Data_out), exp_data);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      edge_n++;
      if (!rst) begin
         model_reset();
      end else begin
         if (edge_n >= free_edge && !bus.empty) begin
            pop_edge  = edge_n;
            free_edge = edge_n + 3;
         end
         exp_read = (pop_edge == edge_n) ? 1 : 0;
         if (edge_n == pop_edge + 2) begin
            exp_reg  = ref_route(int'(bus.X_cur), int'(bus.Y_cur),
                                 int'(bus.Data_in[1:0]), int'(bus.Data_in[3:2]));
            exp_data = int'(bus.Data_in);
         end else begin
            exp_reg = 0;
         end
      end
      @(negedge clk);
      check_outputs(tag);
      $display("cyc %0d %s: rst=%0b empty=%0b Din=%02h read=%0b reg=%0d Dout=%02h",
               edge_n, tag, rst, bus.empty, bus.Data_in, bus.read, bus.register, bus.Data_out);
      // Registered-read FIFO: the popped word appears on Data_in after the READ edge.
      if (fifo_mode) begin
         if (rst && pop_edge == edge_n - 1 && fifo_q.size() > 0) begin
            bus.Data_in = fifo_q.pop_front();
         end
         bus.empty = (fifo_q.size() == 0);
      end
   endtask

   initial begin
      int   reads_seen;
      int   ports [$];
      int   read_edges [$];

      vecs[0] = '{2'd2, 2'd2, 8'h06, 5};
      vecs[1] = '{2'd2, 2'd2, 8'h07, 2};
      vecs[2] = '{2'd2, 2'd2, 8'h0E, 4};
      vecs[3] = '{2'd2, 2'd2, 8'h05, 3};
      vecs[4] = '{2'd2, 2'd2, 8'h0A, 1};
      vecs[5] = '{2'd2, 2'd2, 8'h0F, 2};
      vecs[6] = '{2'd0, 2'd0, 8'hA0, 1};
      vecs[7] = '{2'd3, 2'd0, 8'hF3, 1};
      vecs[8] = '{2'd0, 2'd3, 8'h30, 5};
      vecs[9] = '{2'd3, 2'd3, 8'h0C, 3};

      bus.X_cur   = 2'd2;
      bus.Y_cur   = 2'd2;
      bus.Data_in = 8'h5A;
      bus.empty   = 1'b0;
      model_reset();

      // Reset held with a non-empty FIFO: everything stays at zero.
      repeat (4) tick("reset_hold");
      rst = 1'b1;
      tick("reset_release");
      check("release_read", int'(bus.read), 1);
      bus.empty = 1'b1;
      repeat (4) tick("drain");

      // Routing table: one isolated flit per entry.
      for (int i = 0; i < 10; i++) begin
         bus.X_cur   = vecs[i].xc;
         bus.Y_cur   = vecs[i].yc;
         bus.Data_in = vecs[i].flit;
         bus.empty   = 1'b0;
         tick("vec_read");
         check("vec_read_pulse", int'(bus.read), 1);
         bus.empty = 1'b1;
         tick("vec_load");
         tick("vec_send");
         check("vec_port", int'(bus.register), vecs[i].exp_port);
         check("vec_data", int'(bus.Data_out), int'(vecs[i].flit));
         tick("vec_idle");
         check("vec_clear", int'(bus.register), 0);
         tick("vec_idle2");
      end

      // Back-to-back stream from a FIFO that stays non-empty.
      bus.X_cur   = 2'd2;
      bus.Y_cur   = 2'd2;
      bus.Data_in = 8'h00;
      fifo_q      = '{8'h07, 8'h0E, 8'h06};
      bus.empty   = 1'b0;
      fifo_mode   = 1'b1;
      for (int c = 0; c < 14; c++) begin
         tick("b2b");
         if (bus.read) read_edges.push_back(edge_n);
         if (bus.register != 3'd0) ports.push_back(int'(bus.register));
      end
      fifo_mode = 1'b0;
      check("b2b_nports", ports.size(), 3);
      check("b2b_nreads", read_edges.size(), 3);
      if (ports.size() == 3) begin
         check("b2b_port0", ports[0], 2);
         check("b2b_port1", ports[1], 4);
         check("b2b_port2", ports[2], 5);
      end
      if (read_edges.size() == 3) begin
         check("b2b_gap0", read_edges[1] - read_edges[0], 3);
         check("b2b_gap1", read_edges[2] - read_edges[1], 3);
      end

      // Empty rises while in READ: the flit completes, then no further pop.
      bus.Data_in = 8'h0E;
      bus.empty   = 1'b0;
      tick("er_read");
      bus.empty  = 1'b1;
      reads_seen = 0;
      ports.delete();
      for (int c = 0; c < 5; c++) begin
         tick("er_tail");
         if (bus.read) reads_seen++;
         if (bus.register != 3'd0) ports.push_back(int'(bus.register));
      end
      check("er_no_extra_read", reads_seen, 0);
      check("er_one_send", ports.size(), 1);

      // Asynchronous reset while in LOAD: outputs clear at once, no SEND pulse.
      bus.Data_in = 8'h07;
      bus.empty   = 1'b0;
      tick("rl_read");
      bus.empty = 1'b1;
      tick("rl_load");
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("rl_async_data", int'(bus.Data_out), 0);
      check("rl_async_reg",  int'(bus.register), 0);
      check("rl_async_read", int'(bus.read), 0);
      tick("rl_held");
      tick("rl_held");
      rst = 1'b1;
      tick("rl_idle");
      tick("rl_idle");
      bus.Data_in = 8'h05;
      bus.empty   = 1'b0;
      tick("rl_restart");
      check("rl_restart_read", int'(bus.read), 1);
      bus.empty = 1'b1;
      repeat (4) tick("rl_tail");

      // Randomized traffic with occasional mid-cycle resets.
      for (int c = 0; c < 600; c++) begin
         bus.empty   = ($urandom_range(0, 2) == 0);
         bus.Data_in = 8'($urandom);
         if (c % 50 == 0) begin
            bus.X_cur = 2'($urandom);
            bus.Y_cur = 2'($urandom);
         end
         if ($urandom_range(0, 79) == 0) begin
            #2 rst = 1'b0;
            model_reset();
            #1 check_outputs("rand_async_rst");
            tick("rand_rst");
            rst = 1'b1;
         end else begin
            tick("rand");
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
